// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum states exist only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

  localparam int unsigned BYTE_WIDTH   = 8;
  localparam int unsigned WORD_WIDTH   = 2 * BYTE_WIDTH;
  localparam int unsigned HEADER_WORDS = 2;

  // Header slots: origin first, then the data word count.
  localparam int unsigned HDR_ORIGIN = 0;
  localparam int unsigned HDR_LENGTH = 1;

  typedef enum logic [3:0] {
    ST_ORIGIN_HI,
    ST_ORIGIN_LO,
    ST_LENGTH_HI,
    ST_LENGTH_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_DONE
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    ST_CHECK_HI,
    ST_CHECK_LO,
    ST_ERROR
`endif
  } loader_state_e;

  // States in which a byte may be accepted.
  function automatic logic is_capture_state(loader_state_e s);
    case (s)
      ST_ORIGIN_HI, ST_ORIGIN_LO,
      ST_LENGTH_HI, ST_LENGTH_LO,
      ST_DATA_HI,   ST_DATA_LO:   return 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK_HI,  ST_CHECK_LO:  return 1'b1;
`endif
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/program_loader_byte_to_word_assembler.sv
// Pairs consecutive accepted bytes into a 16-bit word; word_valid_c pulses
// combinationally with the second byte of each pair.
module program_loader_byte_to_word_assembler
  import program_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_byte,
  input  logic                  byte_strobe,
  input  logic                  big_endian,
  output logic [WORD_WIDTH-1:0] word_c,
  output logic                  word_valid_c
);

  logic                  have_first_q, have_first_d;
  logic [BYTE_WIDTH-1:0] first_byte_q, first_byte_d;

  // Track whether the first byte of a pair is held, and hold it.
  always_comb begin
    have_first_d = have_first_q;
    first_byte_d = first_byte_q;
    if (byte_strobe) begin
      if (have_first_q) begin
        have_first_d = 1'b0;
      end else begin
        have_first_d = 1'b1;
        first_byte_d = in_byte;
      end
    end
  end

  // Pair-phase and first-byte registers; reset drops any half word.
  always_ff @(posedge clock) begin
    if (reset) begin
      have_first_q <= 1'b0;
      first_byte_q <= '0;
    end else begin
      have_first_q <= have_first_d;
      first_byte_q <= first_byte_d;
    end
  end

  assign word_valid_c = byte_strobe && have_first_q;
  assign word_c       = big_endian ? {first_byte_q, in_byte} : {in_byte, first_byte_q};

endmodule

// File: rtl/program_loader.sv
// Byte-stream boot loader: origin, length, data words (and a checksum word when
// PROGRAM_LOADER_CHECKSUM_EN is defined) are written to main memory while the
// core is held in reset; the core is released once the image is complete.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter bit          BIG_ENDIAN    = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_data,
  output logic                     core_reset,
  output logic                     load_done,
  output logic                     load_error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_e IMAGE_END_ST = ST_CHECK_HI;
`else
  localparam loader_state_e IMAGE_END_ST = ST_DONE;
`endif

  loader_state_e            state_q, state_d;
  logic [WORD_WIDTH-1:0]    header_q [HEADER_WORDS];
  logic [WORD_WIDTH-1:0]    header_d [HEADER_WORDS];
  logic [ADDRESS_WIDTH-1:0] index_q, index_d;
  logic                     memory_write_enable_q, memory_write_enable_d;
  logic [ADDRESS_WIDTH-1:0] memory_address_q, memory_address_d;
  logic [DATA_WIDTH-1:0]    memory_data_q, memory_data_d;
  logic                     core_reset_q, core_reset_d;
  logic                     load_done_q, load_done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]    sum_q, sum_d;
  logic                     load_error_q, load_error_d;
`endif

  logic                  in_ready_c;
  logic                  byte_strobe_c;
  logic [WORD_WIDTH-1:0] word_c;
  logic                  word_valid_c;

  assign in_ready_c    = is_capture_state(state_q);
  assign byte_strobe_c = in_valid && in_ready_c;

  program_loader_byte_to_word_assembler u_assembler (
    .clock        (clock),
    .reset        (reset),
    .in_byte      (in_data),
    .byte_strobe  (byte_strobe_c),
    .big_endian   (BIG_ENDIAN),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Next-state, counter, header capture and registered output values.
  always_comb begin
    state_d               = state_q;
    header_d              = header_q;
    index_d               = index_q;
    memory_write_enable_d = 1'b0;
    memory_address_d      = memory_address_q;
    memory_data_d         = memory_data_q;
    core_reset_d          = core_reset_q;
    load_done_d           = load_done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d                 = sum_q;
    load_error_d          = load_error_q;
`endif

    case (state_q)
      ST_ORIGIN_HI: if (byte_strobe_c) state_d = ST_ORIGIN_LO;
      ST_ORIGIN_LO: begin
        if (word_valid_c) begin
          header_d[HDR_ORIGIN] = word_c;
          state_d              = ST_LENGTH_HI;
        end
      end
      ST_LENGTH_HI: if (byte_strobe_c) state_d = ST_LENGTH_LO;
      ST_LENGTH_LO: begin
        if (word_valid_c) begin
          header_d[HDR_LENGTH] = word_c;
          index_d              = '0;
          state_d              = (word_c == '0) ? IMAGE_END_ST : ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (byte_strobe_c) state_d = ST_DATA_LO;
      ST_DATA_LO: begin
        // Load the strobe/address/data registers so they present during WRITE.
        if (word_valid_c) begin
          memory_write_enable_d = 1'b1;
          memory_address_d      = ADDRESS_WIDTH'(header_q[HDR_ORIGIN]) + index_q;
          memory_data_d         = DATA_WIDTH'(word_c);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d                 = sum_q + word_c;
`endif
          state_d               = ST_WRITE;
        end
      end
      ST_WRITE: begin
        index_d = index_q + ADDRESS_WIDTH'(1);
        state_d = (index_d == ADDRESS_WIDTH'(header_q[HDR_LENGTH])) ? IMAGE_END_ST : ST_DATA_HI;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK_HI: if (byte_strobe_c) state_d = ST_CHECK_LO;
      ST_CHECK_LO: begin
        if (word_valid_c) begin
          if (word_c == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      ST_ERROR: state_d = ST_ERROR;
`endif
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_ORIGIN_HI;
    endcase

    // Release the core on the same edge that enters DONE.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      core_reset_d = 1'b0;
      load_done_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q               <= ST_ORIGIN_HI;
      header_q              <= '{default: '0};
      index_q               <= '0;
      memory_write_enable_q <= 1'b0;
      memory_address_q      <= '0;
      memory_data_q         <= '0;
      core_reset_q          <= 1'b1;
      load_done_q           <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q                 <= '0;
      load_error_q          <= 1'b0;
`endif
    end else begin
      state_q               <= state_d;
      header_q              <= header_d;
      index_q               <= index_d;
      memory_write_enable_q <= memory_write_enable_d;
      memory_address_q      <= memory_address_d;
      memory_data_q         <= memory_data_d;
      core_reset_q          <= core_reset_d;
      load_done_q           <= load_done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q                 <= sum_d;
      load_error_q          <= load_error_d;
`endif
    end
  end

  assign in_ready            = in_ready_c;
  assign memory_write_enable = memory_write_enable_q;
  assign memory_address      = memory_address_q;
  assign memory_data         = memory_data_q;
  assign core_reset          = core_reset_q;
  assign load_done           = load_done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_error          = load_error_q;
`else
  assign load_error          = 1'b0;
`endif

endmodule
